multicycle_control_fsm: RTL
===========================

# multicycle_control_fsm

Main control state machine for the multicycle processor datapath. It takes the place of the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath mux selects and write strobes. It also handshakes with a variable-latency memory, runs a watchdog on memory stalls, and traps illegal opcodes into a sticky fault state.

## Interface
- MEM_TIMEOUT, 16: maximum consecutive stalled cycles in a memory state before fault; 0 disables the watchdog.
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- op_i  in  7  opcode field of the instruction register (opcode_t)
- mem_ready_i  in  1  memory completes the current request this cycle
- zero_i  in  1  ALU zero flag, used for branch resolution
- mem_req_o  out  1  memory request valid
- mem_write_o  out  1  request is a store
- adr_src_o  out  1  0 = PC, 1 = ALUOut
- ir_write_o  out  1  load instruction register and old PC
- pc_write_o  out  1  PC load strobe
- alu_src_a_o  out  2  00 = PC, 01 = oldPC, 10 = rs1, 11 = zero
- alu_src_b_o  out  2  00 = rs2, 01 = imm, 10 = constant 4
- alu_op_o  out  2  00 = add, 01 = sub/branch, 10 = funct decode
- result_src_o  out  2  00 = ALUOut, 01 = read data, 10 = ALU result
- reg_write_o  out  1  register file write strobe
- fault_o  out  1  sticky fault (illegal opcode or memory timeout)
- state_o  out  4  current state encoding, for debug

## Operation
- State encodings: RESET 0, FETCH 1, DECODE 2, MEMADR 3, MEMREAD 4, MEMWB 5, MEMWRITE 6, EXECR 7, EXECI 8, ALUWB 9, BRANCH 10, JAL 11, LUI 12, JALR_TGT 13, JALR_LINK 14, FAULT 15.
- Any output not listed for a state is 0.
- RESET: all outputs 0; next state FETCH.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, result_src=10.
  - While mem_ready=0, stay in FETCH.
  - On mem_ready=1, pulse ir_write=1 and pc_write=1, then go to DECODE.
- DECODE: a=01, b=01, alu_op=00 (branch target).
  - Next state by op_i: load 0000011 or store 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH; 1101111 → JAL; 0110111 → LUI; 1100111 → JALR_TGT (macro only).
  - Any other opcode → FAULT.
- MEMADR: a=10, b=01. Next state MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: mem_req=1, adr_src=1. Wait for mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1; next state FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Wait for mem_ready, then FETCH.
- EXECR: a=10, b=00, alu_op=10; next state ALUWB.
- EXECI: a=10, b=01, alu_op=10; next state ALUWB.
- ALUWB: reg_write=1, result_src=00; next state FETCH.
- BRANCH: a=10, b=00, alu_op=01, result_src=00, pc_write=zero_i; next state FETCH.
- JAL: a=01, b=10, result_src=00, pc_write=1; next state ALUWB (rd = oldPC+4).
- LUI: a=11, b=01; next state ALUWB.
- JALR_TGT: a=10, b=01, result_src=10, pc_write=1; next state JALR_LINK.
- JALR_LINK: a=01, b=10; next state ALUWB.
- FAULT: all outputs 0 except fault_o=1. Left only by reset.
- Watchdog: a stall counter wide enough for MEM_TIMEOUT.
  - Increments each cycle in FETCH, MEMREAD or MEMWRITE while mem_ready_i=0.
  - Clears on mem_ready_i=1 or on leaving the state.
  - When the counter equals MEM_TIMEOUT with mem_ready_i still 0, the next state is FAULT.
  - mem_ready_i=1 in that same cycle wins: the request completes and no fault is raised.

## Timing
- Reset: state RESET, counter 0, every output 0 (state_o=0) while rst_ni is low and in the first cycle after release.
- All outputs are combinational from the registered state; ir_write, pc_write and BRANCH's pc_write are also combinational from mem_ready_i or zero_i.
- Zero-wait-state latency in cycles, FETCH through return to FETCH:
  - R-type, I-type, LUI: 4
  - branch: 3
  - store: 4
  - load: 5
  - JAL: 4
  - JALR: 5
- Each cycle of mem_ready_i=0 adds one cycle.
- mem_req_o stays asserted and its address select stays stable until mem_ready_i=1.
- A reset asserted mid-request drops mem_req_o immediately (asynchronous).

## Configuration
- PROC_JALR_EN defined: opcode 1100111 decodes to JALR_TGT → JALR_LINK → ALUWB.
- Not defined: 1100111 is illegal and goes to FAULT; states 13 and 14 are unreachable.

## Test plan
- addi x1,x0,5 with mem_ready_i tied 1 → state_o sequence 1,2,8,9,1; reg_write_o high only in the cycle with state_o=9.
- lw with mem_ready_i low for 3 cycles in MEMREAD → mem_req_o=1 and adr_src_o=1 held 4 cycles; no fault; reg_write_o in MEMWB.
- beq with zero_i=1, then with zero_i=0 → pc_write_o=1 in BRANCH for the first, 0 for the second.
- op_i=1111111 at DECODE → FAULT; fault_o=1 persists 20 cycles; after an rst_ni pulse, state_o=0 then 1.
- MEM_TIMEOUT=4 with mem_ready_i held 0 in FETCH → FAULT entered exactly 5 cycles after entering FETCH; mem_ready_i=1 on the 5th cycle → DECODE instead.
- jalr with and without PROC_JALR_EN → state_o 13,14,9 with pc_write_o in state 13, versus FAULT.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle processor control FSM: sequences fetch/decode/execute/memory/writeback.
// Outputs decode combinationally from the registered state (strobes also from mem_ready_i/zero_i).
// Memory states hold mem_req_o until mem_ready_i; a stall watchdog traps to the sticky FAULT state.
// Optional feature: define PROC_JALR_EN to decode JALR (1100111) instead of trapping it.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] op_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       adr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] result_src_o,
  output logic       reg_write_o,
  output logic       fault_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEMADR    = 4'd3,
    S_MEMREAD   = 4'd4,
    S_MEMWB     = 4'd5,
    S_MEMWRITE  = 4'd6,
    S_EXECR     = 4'd7,
    S_EXECI     = 4'd8,
    S_ALUWB     = 4'd9,
    S_BRANCH    = 4'd10,
    S_JAL       = 4'd11,
    S_LUI       = 4'd12,
    S_JALR_TGT  = 4'd13,
    S_JALR_LINK = 4'd14,
    S_FAULT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Counter must be able to hold MEM_TIMEOUT itself so the equality test can fire.
  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t        state_q;
  logic [CW-1:0] stall_q;
  logic          is_store_q;
  logic          stall_expired;

  // Watchdog fires on the cycle the counter reaches the limit; mem_ready_i still has priority.
  assign stall_expired = (MEM_TIMEOUT != 0) && (stall_q == CW'(MEM_TIMEOUT));

  // State sequencing, stall counter and load/store selection captured at decode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_RESET;
      stall_q    <= '0;
      is_store_q <= 1'b0;
    end else begin
      // Counter clears on any cycle that does not remain stalled in a memory state.
      stall_q <= '0;
      case (state_q)
        S_RESET: state_q <= S_FETCH;
        S_FETCH, S_MEMREAD, S_MEMWRITE: begin
          if (mem_ready_i) begin
            case (state_q)
              S_FETCH:   state_q <= S_DECODE;
              S_MEMREAD: state_q <= S_MEMWB;
              default:   state_q <= S_FETCH;
            endcase
          end else if (stall_expired) begin
            state_q <= S_FAULT;
          end else if (MEM_TIMEOUT != 0) begin
            stall_q <= stall_q + 1'b1;
          end
        end
        S_DECODE: begin
          is_store_q <= (op_i == OP_STORE);
          case (op_i)
            OP_LOAD, OP_STORE: state_q <= S_MEMADR;
            OP_RTYPE:          state_q <= S_EXECR;
            OP_ITYPE:          state_q <= S_EXECI;
            OP_BRANCH:         state_q <= S_BRANCH;
            OP_JAL:            state_q <= S_JAL;
            OP_LUI:            state_q <= S_LUI;
`ifdef PROC_JALR_EN
            OP_JALR:           state_q <= S_JALR_TGT;
`endif
            default:           state_q <= S_FAULT;
          endcase
        end
        S_MEMADR:    state_q <= is_store_q ? S_MEMWRITE : S_MEMREAD;
        S_MEMWB:     state_q <= S_FETCH;
        S_EXECR:     state_q <= S_ALUWB;
        S_EXECI:     state_q <= S_ALUWB;
        S_ALUWB:     state_q <= S_FETCH;
        S_BRANCH:    state_q <= S_FETCH;
        S_JAL:       state_q <= S_ALUWB;
        S_LUI:       state_q <= S_ALUWB;
        S_JALR_TGT:  state_q <= S_JALR_LINK;
        S_JALR_LINK: state_q <= S_ALUWB;
        S_FAULT:     state_q <= S_FAULT;
        default:     state_q <= S_FAULT;
      endcase
    end
  end

  // Datapath control decode from the current state; unlisted outputs stay 0.
  always_comb begin
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    adr_src_o    = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    result_src_o = 2'b00;
    reg_write_o  = 1'b0;
    fault_o      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o    = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_o   = mem_ready_i;
        pc_write_o   = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
      end
      S_MEMREAD: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
      end
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        adr_src_o   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_op_o    = 2'b10;
      end
      S_ALUWB: reg_write_o = 1'b1;
      S_BRANCH: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b01;
        pc_write_o  = zero_i;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write_o  = 1'b1;
      end
      S_LUI: begin
        alu_src_a_o = 2'b11;
        alu_src_b_o = 2'b01;
      end
      S_JALR_TGT: begin
        alu_src_a_o  = 2'b10;
        alu_src_b_o  = 2'b01;
        result_src_o = 2'b10;
        pc_write_o   = 1'b1;
      end
      S_JALR_LINK: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
      end
      S_FAULT: fault_o = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule
